// File: rtl/adder_tpg_gen.sv
// Operand-pair pattern generator for adder test: LFSR, ramp, walking-one and
// corner-case modes, delivered over a valid/ready handshake with start/busy/done.
module adder_tpg_gen #(
  parameter int               WIDTH    = 16,
  parameter int               PATTERNS = 100,
  parameter int               SEED     = 1,
  parameter logic [WIDTH-1:0] TAPS     = 16'hE010,
  parameter int               A_STEP   = 511,
  parameter int               B_STEP   = 509
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] SEED_L   = (SEED == 0) ? WIDTH'(1) : WIDTH'(SEED);
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] A_STEP_L = WIDTH'(A_STEP);
  localparam logic [WIDTH-1:0] B_STEP_L = WIDTH'(B_STEP);
  localparam logic [15:0]      LAST     = 16'(PATTERNS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_mode;
  logic [15:0]      r_i;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_ramp_a;
  logic [WIDTH-1:0] r_ramp_b;
  logic [WIDTH-1:0] r_walk;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_load;
  logic             w_advance;
  logic [1:0]       w_mode_n;
  logic [15:0]      w_i_n;
  logic [WIDTH-1:0] w_lfsr_n;
  logic [WIDTH-1:0] w_ramp_a_n;
  logic [WIDTH-1:0] w_ramp_b_n;
  logic [WIDTH-1:0] w_walk_n;
  logic [WIDTH-1:0] w_lfsr_rev;
  logic [WIDTH-1:0] w_pat_a;
  logic [WIDTH-1:0] w_pat_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_load       = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: if (ready) begin
        if (r_i == LAST) w_next_state = S_DONE;
        else             w_advance    = 1'b1;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next-pattern state: either the run's initial values or one step on from the current ones.
  assign w_mode_n   = w_load ? mode     : r_mode;
  assign w_i_n      = w_load ? 16'd0    : r_i + 16'd1;
  assign w_lfsr_n   = w_load ? SEED_L   : {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
  assign w_ramp_a_n = w_load ? ONES     : r_ramp_a - A_STEP_L;
  assign w_ramp_b_n = w_load ? WIDTH'(1) : r_ramp_b + B_STEP_L;
  assign w_walk_n   = w_load ? WIDTH'(1) : {r_walk[WIDTH-2:0], r_walk[WIDTH-1]};

  always_comb begin
    w_lfsr_rev = '0;
    for (int n = 0; n < WIDTH; n++) w_lfsr_rev[n] = w_lfsr_n[WIDTH-1-n];
  end

  always_comb begin
    w_pat_a = '0;
    w_pat_b = '0;
    case (w_mode_n)
      2'd0: begin
        w_pat_a = w_ramp_a_n ^ w_lfsr_n;
        w_pat_b = w_ramp_b_n ^ w_lfsr_n;
      end
      2'd1: begin
        w_pat_a = w_lfsr_n;
        w_pat_b = w_lfsr_rev;
      end
      2'd2: begin
        w_pat_a = w_walk_n;
        w_pat_b = ~w_walk_n;
      end
      default: begin
        case (w_i_n[1:0])
          2'd0:    begin w_pat_a = '0;       w_pat_b = '0;        end
          2'd1:    begin w_pat_a = ONES;     w_pat_b = WIDTH'(1); end
          2'd2:    begin w_pat_a = ONES;     w_pat_b = ONES;      end
          default: begin w_pat_a = MSB_ONLY; w_pat_b = MSB_ONLY;  end
        endcase
      end
    endcase
  end

  // Walking-one uses a rotating register so i mod WIDTH never needs a divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode   <= 2'd0;
      r_i      <= 16'd0;
      r_lfsr   <= SEED_L;
      r_ramp_a <= '0;
      r_ramp_b <= '0;
      r_walk   <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_load || w_advance) begin
      r_mode   <= w_mode_n;
      r_i      <= w_i_n;
      r_lfsr   <= w_lfsr_n;
      r_ramp_a <= w_ramp_a_n;
      r_ramp_b <= w_ramp_b_n;
      r_walk   <= w_walk_n;
      r_a      <= w_pat_a;
      r_b      <= w_pat_b;
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign valid = (r_state == S_RUN);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign count = r_i;

endmodule
